cacheline_adapter: RTL

Responder on the cache's line-wide physical-memory port (pmem_*), and initiator on a narrow burst memory bus. It accepts a full-line read or write from a cache, splits it into fixed-order beats on the burst bus, and answers with a single-cycle pmem_resp. It sits between the L1 caches (or their arbiter) and main memory.

---
 rtl/cacheline_adapter_pkg.sv | 23 ++
 rtl/cacheline_adapter_beat_buffer.sv | 48 ++++
 rtl/cacheline_adapter.sv | 118 +++++++++++
 3 files changed

// File: rtl/cacheline_adapter_pkg.sv
// Shared types and sizing for the cache-line to burst-bus adapter.
package cacheline_adapter_pkg;

  localparam int LINE_W     = 256;
  localparam int BURST_W    = 64;
  localparam int OFFSET_W   = 5;
  localparam int BEATS      = LINE_W / BURST_W;
  localparam int BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    RESP,
    GUARD
  } state_t;

  // A single-beat line still needs a 1-bit counter.
  function automatic int idx_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/cacheline_adapter_beat_buffer.sv
// Line storage: the assembled read line (written one beat at a time) and the
// captured write line (loaded whole, read back one beat at a time).
module cacheline_adapter_beat_buffer
  import cacheline_adapter_pkg::*;
#(
  parameter int S_LINE  = LINE_W,
  parameter int S_BURST = BURST_W,
  parameter int IDX_W   = BEAT_IDX_W
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic [S_BURST-1:0] i_din,
  input  logic               i_cap,
  input  logic [S_LINE-1:0]  i_cap_line,
  output logic [S_BURST-1:0] o_wbeat,
  output logic [S_LINE-1:0]  o_rline
);

  localparam int NB = S_LINE / S_BURST;

  logic [S_BURST-1:0] w_wr_slot [NB];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_slot
      logic [S_BURST-1:0] r_rd;
      logic [S_BURST-1:0] r_wr;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_rd <= '0;
          r_wr <= '0;
        end else begin
          if (i_load && (i_idx == IDX_W'(gi))) r_rd <= i_din;
          if (i_cap) r_wr <= i_cap_line[gi*S_BURST +: S_BURST];
        end
      end

      assign o_rline[gi*S_BURST +: S_BURST] = r_rd;
      assign w_wr_slot[gi]                  = r_wr;
    end
  endgenerate

  assign o_wbeat = w_wr_slot[i_idx];

endmodule

// File: rtl/cacheline_adapter.sv
// Accepts a full-line read/write on the pmem port and runs it as a fixed-order
// beat burst on the narrow memory bus, answering with a one-cycle pmem_resp.
module cacheline_adapter
  import cacheline_adapter_pkg::*;
#(
  parameter int S_LINE   = LINE_W,
  parameter int S_BURST  = BURST_W,
  parameter int S_OFFSET = OFFSET_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_pmem_read,
  input  logic               i_pmem_write,
  input  logic [31:0]        i_pmem_addr,
  input  logic [S_LINE-1:0]  i_pmem_wdata,
  output logic [S_LINE-1:0]  o_pmem_rdata,
  output logic               o_pmem_resp,
  output logic               o_pmem_error,
  output logic               o_burst_read,
  output logic               o_burst_write,
  output logic [31:0]        o_burst_addr,
  output logic [S_BURST-1:0] o_burst_wdata,
  input  logic [S_BURST-1:0] i_burst_rdata,
  input  logic               i_burst_resp,
  input  logic               i_burst_error
);

  localparam int                NB    = S_LINE / S_BURST;
  localparam int                IDX_W = idx_width(NB);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(NB - 1);
  localparam logic [31:0]       MASK  = ~((32'd1 << S_OFFSET) - 32'd1);

  state_t           r_state, w_state_next;
  logic [IDX_W-1:0] r_cnt, w_cnt_next;
  logic             r_err, w_err_next;
  logic [31:0]      r_addr, w_addr_next;
  logic             w_cap;
  logic             w_load;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      r_addr  <= w_addr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    w_addr_next  = r_addr;
    w_cap        = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_pmem_read ^ i_pmem_write) begin
          w_addr_next  = i_pmem_addr & MASK;
          w_cnt_next   = '0;
          w_err_next   = 1'b0;
          w_cap        = i_pmem_write;
          w_state_next = i_pmem_read ? READ : WRITE;
        end else if (i_pmem_read && i_pmem_write) begin
          // Conflicting request: fail it without touching the bus.
          w_err_next   = 1'b1;
          w_state_next = RESP;
        end
      end
      READ, WRITE: begin
        if (i_burst_error) begin
          w_err_next   = 1'b1;
          w_state_next = RESP;
        end else if (i_burst_resp) begin
          w_load = (r_state == READ);
          // Completion comes from the pre-increment count, not the wrap.
          if (r_cnt == LAST) begin
            w_cnt_next   = '0;
            w_state_next = RESP;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
      RESP:    w_state_next = GUARD;
      GUARD:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  cacheline_adapter_beat_buffer #(
    .S_LINE  (S_LINE),
    .S_BURST (S_BURST),
    .IDX_W   (IDX_W)
  ) u_buf (
    .i_clk      (i_clk),
    .i_rst      (i_reset),
    .i_load     (w_load),
    .i_idx      (r_cnt),
    .i_din      (i_burst_rdata),
    .i_cap      (w_cap),
    .i_cap_line (i_pmem_wdata),
    .o_wbeat    (o_burst_wdata),
    .o_rline    (o_pmem_rdata)
  );

  assign o_burst_read  = (r_state == READ);
  assign o_burst_write = (r_state == WRITE);
  assign o_burst_addr  = r_addr;
  assign o_pmem_resp   = (r_state == RESP);
  assign o_pmem_error  = (r_state == RESP) && r_err;

endmodule
